// File: rtl/ltl_monitor_seq_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for an LTL automata cluster: drives reset/run/symbols,
// captures reports two cycles after each symbol, queues them in a FWFT FIFO.
module ltl_monitor_seq_ctrl #(
    parameter int REPORT_W    = 16,
    parameter int CNT_W       = 16,
    parameter int RFIFO_DEPTH = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                auto_reset,
    output logic                auto_run,
    output logic [7:0]          auto_symbols,
    input  logic [REPORT_W-1:0] auto_report,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [REPORT_W-1:0] rpt_bits,
    output logic [CNT_W-1:0]    rpt_index,
    output logic                rpt_frame_end,
    output logic                busy
);

    localparam int PTR_W = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(RFIFO_DEPTH + 1);
    localparam int IC_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IDX_MAX = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RFIFO_DEPTH - 1);
    localparam logic [IC_W-1:0]  IC_LAST  = IC_W'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [IC_W-1:0]  init_cnt;
    logic [CNT_W-1:0] idx;

    logic             last1;
    logic [CNT_W-1:0] idx1;
    logic             v2;
    logic             last2;
    logic [CNT_W-1:0] idx2;

    logic [REPORT_W-1:0] mem_bits [RFIFO_DEPTH];
    logic [CNT_W-1:0]    mem_idx  [RFIFO_DEPTH];
    logic                mem_fe   [RFIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OCC_W-1:0]    count;
    logic [OCC_W-1:0]    count_next;
    logic [1:0]          inflight_next;

    logic accept;
    logic push;
    logic pop;
    logic ready_next;

    assign accept = in_valid & in_ready;
    assign push   = v2 & ((auto_report != '0) | last2);
    assign pop    = rpt_valid & rpt_ready;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (enable) state_next = INIT;
            end
            INIT: begin
                if (init_cnt == IC_LAST) state_next = RUN;
            end
            RUN: begin
                if (accept && in_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (!auto_run && !v2) state_next = enable ? INIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is registered from next-cycle occupancy, so push/pop/accept
    // of this cycle are already accounted for.
    always_comb begin
        count_next    = count + OCC_W'(push) - OCC_W'(pop);
        inflight_next = {1'b0, accept} + {1'b0, auto_run};
        ready_next    = (state_next == RUN) &&
                        ((int'(count_next) + int'(inflight_next)) < RFIFO_DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            init_cnt   <= '0;
            in_ready   <= 1'b0;
            auto_reset <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            init_cnt   <= (state == INIT) ? init_cnt + IC_W'(1) : '0;
            in_ready   <= ready_next;
            auto_reset <= (state_next == INIT);
            busy       <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (state == INIT) begin
            idx <= '0;
        end else if (accept && idx != IDX_MAX) begin
            idx <= idx + CNT_W'(1);
        end
    end

    // Two-stage capture pipe: stage 1 is the run strobe itself, stage 2
    // lines up with the automata's registered report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_run     <= 1'b0;
            auto_symbols <= '0;
            last1        <= 1'b0;
            idx1         <= '0;
            v2           <= 1'b0;
            last2        <= 1'b0;
            idx2         <= '0;
        end else begin
            auto_run <= accept;
            v2       <= auto_run;
            last2    <= last1;
            idx2     <= idx1;
            if (accept) begin
                auto_symbols <= in_data;
                last1        <= in_last;
                idx1         <= idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RFIFO_DEPTH; i++) begin
                mem_bits[i] <= '0;
                mem_idx[i]  <= '0;
                mem_fe[i]   <= 1'b0;
            end
        end else begin
            count <= count_next;
            if (push) begin
                mem_bits[wr_ptr] <= auto_report;
                mem_idx[wr_ptr]  <= idx2;
                mem_fe[wr_ptr]   <= last2;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rpt_valid     = (count != '0);
    assign rpt_bits      = mem_bits[rd_ptr];
    assign rpt_index     = mem_idx[rd_ptr];
    assign rpt_frame_end = mem_fe[rd_ptr];

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && !pop && (int'(count) == RFIFO_DEPTH))
    );

endmodule
